// File: rtl/bus_arbiter.sv
// Bus control unit: arbitrates the external V30MZ bus between EU transfers and prefetches.
// Optional macro BUS_TIMEOUT_EN adds a readyb wait limit that aborts hung bus cycles.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  eu_cmd,
    input  logic [19:0] eu_addr,
    input  logic        eu_word,
    input  logic [15:0] eu_wdata,
    output logic        eu_done,
    output logic [15:0] eu_rdata,
    input  logic        pf_req,
    input  logic        pf_flush,
    input  logic [19:0] pf_addr,
    output logic        pf_push,
    output logic [15:0] pf_data,
    output logic        pf_byte,
    input  logic        readyb,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic [19:0] address_out,
    output logic [3:0]  bus_status,
    output logic        bus_upper_byte_enable,
    output logic        bus_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EU_LO = 2'd2;
    localparam logic [1:0] S_EU_HI = 2'd3;

    localparam logic [2:0] CMD_MEM_READ  = 3'd1;
    localparam logic [2:0] CMD_MEM_WRITE = 3'd2;
    localparam logic [2:0] CMD_IO_READ   = 3'd3;
    localparam logic [2:0] CMD_IO_WRITE  = 3'd4;

    localparam logic [3:0] STS_IDLE   = 4'hF;
    localparam logic [3:0] STS_MEM_RD = 4'h9;
    localparam logic [3:0] STS_MEM_WR = 4'hA;
    localparam logic [3:0] STS_IO_RD  = 4'h5;
    localparam logic [3:0] STS_IO_WR  = 4'h6;

    function automatic logic cmd_valid(input logic [2:0] c);
        return (c >= CMD_MEM_READ) && (c <= CMD_IO_WRITE);
    endfunction

    function automatic logic is_write(input logic [2:0] c);
        return (c == CMD_MEM_WRITE) || (c == CMD_IO_WRITE);
    endfunction

    function automatic logic [3:0] cmd_status(input logic [2:0] c);
        case (c)
            CMD_MEM_READ:  return STS_MEM_RD;
            CMD_MEM_WRITE: return STS_MEM_WR;
            CMD_IO_READ:   return STS_IO_RD;
            CMD_IO_WRITE:  return STS_IO_WR;
            default:       return STS_IDLE;
        endcase
    endfunction

    // Write data for the first (or only) bus cycle, steered onto the addressed lane.
    function automatic logic [15:0] first_wdata(input logic odd, input logic word,
                                                input logic [15:0] w);
        if (odd)       return {w[7:0], 8'h00};
        else if (word) return w;
        else           return {8'h00, w[7:0]};
    endfunction

    // Read data for an unsplit transfer; byte reads come back zero-extended.
    function automatic logic [15:0] single_rdata(input logic odd, input logic word,
                                                 input logic [15:0] d);
        if (word && !odd) return d;
        else if (odd)     return {8'h00, d[15:8]};
        else              return {8'h00, d[7:0]};
    endfunction

    logic [1:0]  state;
    logic [2:0]  cmd_q;
    logic [19:0] addr_q;
    logic        word_q;
    logic [15:0] wdata_q;
    logic        pf_odd_q;
    logic        discard;
    logic [7:0]  rd_lo_q;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt;
`else
    assign bus_error = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; later assignments in
    // the same block deliberately override earlier ones (abort wins over the case).
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= S_IDLE;
            cmd_q                 <= 3'd0;
            addr_q                <= 20'd0;
            word_q                <= 1'b0;
            wdata_q               <= 16'd0;
            pf_odd_q              <= 1'b0;
            discard               <= 1'b0;
            rd_lo_q               <= 8'd0;
            eu_done               <= 1'b0;
            eu_rdata              <= 16'd0;
            pf_push               <= 1'b0;
            pf_data               <= 16'd0;
            pf_byte               <= 1'b0;
            data_out              <= 16'd0;
            address_out           <= 20'hFFFFF;
            bus_status            <= STS_IDLE;
            bus_upper_byte_enable <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            to_cnt                <= '0;
            bus_error             <= 1'b0;
`endif
        end else begin
            eu_done <= 1'b0;
            pf_push <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            bus_error <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    discard <= 1'b0;
                    // eu_done is still high while the EU drops its request, so mask it.
                    if (cmd_valid(eu_cmd) && !eu_done) begin
                        state                 <= S_EU_LO;
                        cmd_q                 <= eu_cmd;
                        addr_q                <= eu_addr;
                        word_q                <= eu_word;
                        wdata_q               <= eu_wdata;
                        address_out           <= eu_addr;
                        bus_status            <= cmd_status(eu_cmd);
                        bus_upper_byte_enable <= eu_word | eu_addr[0];
                        if (is_write(eu_cmd))
                            data_out <= first_wdata(eu_addr[0], eu_word, eu_wdata);
                    end else if (pf_req && !pf_flush) begin
                        state                 <= S_FETCH;
                        pf_odd_q              <= pf_addr[0];
                        address_out           <= pf_addr;
                        bus_status            <= STS_MEM_RD;
                        bus_upper_byte_enable <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (pf_flush)
                        discard <= 1'b1;
                    if (!readyb) begin
                        state      <= S_IDLE;
                        bus_status <= STS_IDLE;
                        discard    <= 1'b0;
                        if (!discard && !pf_flush) begin
                            pf_push <= 1'b1;
                            pf_data <= data_in;
                            pf_byte <= pf_odd_q;
                        end
                    end
                end

                S_EU_LO: begin
                    if (!readyb) begin
                        if (word_q && addr_q[0]) begin
                            // Odd word: second half goes to addr+1 on the low lane.
                            state                 <= S_EU_HI;
                            rd_lo_q               <= data_in[15:8];
                            address_out           <= addr_q + 20'd1;
                            bus_upper_byte_enable <= 1'b0;
                            if (is_write(cmd_q))
                                data_out <= {8'h00, wdata_q[15:8]};
                        end else begin
                            state      <= S_IDLE;
                            bus_status <= STS_IDLE;
                            eu_done    <= 1'b1;
                            if (!is_write(cmd_q))
                                eu_rdata <= single_rdata(addr_q[0], word_q, data_in);
                        end
                    end
                end

                S_EU_HI: begin
                    if (!readyb) begin
                        state      <= S_IDLE;
                        bus_status <= STS_IDLE;
                        eu_done    <= 1'b1;
                        if (!is_write(cmd_q))
                            eu_rdata <= {data_in[7:0], rd_lo_q};
                    end
                end

                default: state <= S_IDLE;
            endcase

`ifdef BUS_TIMEOUT_EN
            // Idle or any completed bus cycle restarts the count for the next cycle.
            if (state == S_IDLE || !readyb) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt     <= '0;
                state      <= S_IDLE;
                bus_status <= STS_IDLE;
                discard    <= 1'b0;
                bus_error  <= 1'b1;
                if (state != S_FETCH) begin
                    eu_done  <= 1'b1;
                    eu_rdata <= 16'hFFFF;
                end
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a bus responder checks each bus cycle as it starts,
// and a response monitor checks eu_done / pf_push pulses against queued expectations.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  eu_cmd;
    logic [19:0] eu_addr;
    logic        eu_word;
    logic [15:0] eu_wdata;
    logic        eu_done;
    logic [15:0] eu_rdata;
    logic        pf_req;
    logic        pf_flush;
    logic [19:0] pf_addr;
    logic        pf_push;
    logic [15:0] pf_data;
    logic        pf_byte;
    logic        readyb = 1'b1;
    logic [15:0] data_in = 16'd0;
    logic [15:0] data_out;
    logic [19:0] address_out;
    logic [3:0]  bus_status;
    logic        bus_upper_byte_enable;
    logic        bus_error;

    bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .eu_cmd(eu_cmd), .eu_addr(eu_addr), .eu_word(eu_word), .eu_wdata(eu_wdata),
        .eu_done(eu_done), .eu_rdata(eu_rdata),
        .pf_req(pf_req), .pf_flush(pf_flush), .pf_addr(pf_addr),
        .pf_push(pf_push), .pf_data(pf_data), .pf_byte(pf_byte),
        .readyb(readyb), .data_in(data_in), .data_out(data_out),
        .address_out(address_out), .bus_status(bus_status),
        .bus_upper_byte_enable(bus_upper_byte_enable), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] addr;
        logic [3:0]  status;
        logic        ube;
        logic [15:0] dout;
        int          waits;
        logic [15:0] rd;
    } bus_exp_t;

    typedef struct {
        logic        is_pf;
        logic [15:0] data;
        logic        pbyte;
        logic        err;
    } rsp_exp_t;

    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic push_bus(input logic [19:0] a, input logic [3:0] st, input logic u,
                            input logic [15:0] dout, input int w, input logic [15:0] rd);
        bus_exp_t e;
        e.addr = a; e.status = st; e.ube = u; e.dout = dout; e.waits = w; e.rd = rd;
        exp_bus.push_back(e);
    endtask

    task automatic push_rsp(input logic is_pf, input logic [15:0] d, input logic pb, input logic err);
        rsp_exp_t r;
        r.is_pf = is_pf; r.data = d; r.pbyte = pb; r.err = err;
        exp_rsp.push_back(r);
    endtask

    // Bus responder: checks the bus outputs at the start of each bus cycle, then
    // inserts the queued number of wait states before pulling readyb low.
    int          cur_wait = 0;
    logic        in_cycle = 1'b0;
    logic [15:0] cur_rd = 16'd0;

    always @(negedge clk) begin
        if (reset || bus_status == 4'hF) begin
            readyb   = 1'b1;
            in_cycle = 1'b0;
        end else begin
            if (!in_cycle) begin
                in_cycle = 1'b1;
                check("bus_cycle_expected", 32'(exp_bus.size() != 0), 32'd1);
                if (exp_bus.size() != 0) begin
                    bus_exp_t e;
                    e = exp_bus.pop_front();
                    check("bus_addr", 32'(address_out), 32'(e.addr));
                    check("bus_status", 32'(bus_status), 32'(e.status));
                    check("bus_ube", 32'(bus_upper_byte_enable), 32'(e.ube));
                    if (e.status == 4'hA || e.status == 4'h6)
                        check("bus_data_out", 32'(data_out), 32'(e.dout));
                    cur_wait = e.waits;
                    cur_rd   = e.rd;
                end else begin
                    cur_wait = 0;
                    cur_rd   = 16'd0;
                end
            end
            if (cur_wait > 0) begin
                readyb = 1'b1;
                cur_wait--;
            end else begin
                readyb   = 1'b0;
                data_in  = cur_rd;
                in_cycle = 1'b0;
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (!reset && (eu_done || pf_push)) begin
            check("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
            if (exp_rsp.size() != 0) begin
                rsp_exp_t r;
                r = exp_rsp.pop_front();
                check("rsp_kind_pf", 32'(pf_push), 32'(r.is_pf));
                check("rsp_bus_error", 32'(bus_error), 32'(r.err));
                check("rsp_status_idle", 32'(bus_status), 32'hF);
                if (pf_push) begin
                    check("pf_data", 32'(pf_data), 32'(r.data));
                    check("pf_byte", 32'(pf_byte), 32'(r.pbyte));
                end else begin
                    check("eu_rdata", 32'(eu_rdata), 32'(r.data));
                end
            end
        end
    end

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus_status == 4'hF && !eu_done && !pf_push) ok = 1'b1;
        end
        check("idle_reached", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Holds the EU request until eu_done, and one edge beyond it (must be ignored).
    task automatic eu_op(input logic [2:0] c, input logic [19:0] a, input logic w, input logic [15:0] wd);
        logic got = 1'b0;
        eu_cmd = c; eu_addr = a; eu_word = w; eu_wdata = wd;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (eu_done) got = 1'b1;
        end
        check("eu_done_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        eu_cmd = 3'd0;
    endtask

    task automatic fetch_op(input logic [19:0] a, input logic flush);
        pf_addr = a;
        pf_req  = 1'b1;
        @(posedge clk);
        #1;
        pf_req = 1'b0;
        if (flush) begin
            @(posedge clk);
            #1 pf_flush = 1'b1;
            @(posedge clk);
            #1 pf_flush = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        eu_cmd = 3'd0; eu_addr = 20'd0; eu_word = 1'b0; eu_wdata = 16'd0;
        pf_req = 1'b1; pf_flush = 1'b0; pf_addr = 20'hFFFF0;

        // Reset held three edges; pf_req already waiting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_address", 32'(address_out), 32'hFFFFF);
        check("rst_status", 32'(bus_status), 32'hF);
        check("rst_ube", 32'(bus_upper_byte_enable), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_eu_rdata", 32'(eu_rdata), 32'd0);
        check("rst_pf_data", 32'(pf_data), 32'd0);
        check("rst_pulses", 32'({eu_done, pf_push, bus_error, pf_byte}), 32'd0);
        push_bus(20'hFFFF0, 4'h9, 1'b1, 16'h0000, 0, 16'hC0DE);
        push_rsp(1'b1, 16'hC0DE, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 pf_req = 1'b0;
        wait_idle();

        // Odd fetch with two wait states.
        push_bus(20'h00101, 4'h9, 1'b1, 16'h0000, 2, 16'hAB12);
        push_rsp(1'b1, 16'hAB12, 1'b1, 1'b0);
        fetch_op(20'h00101, 1'b0);

        // Odd word read split across two bus cycles.
        push_bus(20'h2000F, 4'h9, 1'b1, 16'h0000, 1, 16'h3400);
        push_bus(20'h20010, 4'h9, 1'b0, 16'h0000, 0, 16'h0012);
        push_rsp(1'b0, 16'h1234, 1'b0, 1'b0);
        eu_op(3'd1, 20'h2000F, 1'b1, 16'h0000);

        // Even byte read, odd IO byte read, even word read.
        push_bus(20'h00200, 4'h9, 1'b0, 16'h0000, 0, 16'h77CC);
        push_rsp(1'b0, 16'h00CC, 1'b0, 1'b0);
        eu_op(3'd1, 20'h00200, 1'b0, 16'h0000);
        push_bus(20'h00301, 4'h5, 1'b1, 16'h0000, 1, 16'hEE11);
        push_rsp(1'b0, 16'h00EE, 1'b0, 1'b0);
        eu_op(3'd3, 20'h00301, 1'b0, 16'h0000);
        push_bus(20'h00400, 4'h9, 1'b1, 16'h0000, 0, 16'hBEEF);
        push_rsp(1'b0, 16'hBEEF, 1'b0, 1'b0);
        eu_op(3'd1, 20'h00400, 1'b1, 16'h0000);

        // IO byte write at odd address racing a prefetch: EU first, fetch after eu_done.
        push_bus(20'h00041, 4'h6, 1'b1, 16'h5A00, 0, 16'h0000);
        push_bus(20'h00500, 4'h9, 1'b1, 16'h0000, 0, 16'h1357);
        push_rsp(1'b0, 16'hBEEF, 1'b0, 1'b0);
        push_rsp(1'b1, 16'h1357, 1'b0, 1'b0);
        pf_addr = 20'h00500;
        pf_req  = 1'b1;
        eu_op(3'd4, 20'h00041, 1'b0, 16'h005A);
        pf_req = 1'b0;
        wait_idle();

        // Even byte write and even word write.
        push_bus(20'h00600, 4'hA, 1'b0, 16'h00C3, 1, 16'h0000);
        push_rsp(1'b0, 16'hBEEF, 1'b0, 1'b0);
        eu_op(3'd2, 20'h00600, 1'b0, 16'h12C3);
        push_bus(20'h00700, 4'hA, 1'b1, 16'hA55A, 0, 16'h0000);
        push_rsp(1'b0, 16'hBEEF, 1'b0, 1'b0);
        eu_op(3'd2, 20'h00700, 1'b1, 16'hA55A);

        // Flush mid-fetch: bus cycle completes, no push.
        push_bus(20'h00800, 4'h9, 1'b1, 16'h0000, 3, 16'h4444);
        fetch_op(20'h00800, 1'b1);

        // Odd word write at the top of memory wraps to 00000.
        push_bus(20'hFFFFF, 4'hA, 1'b1, 16'hAD00, 0, 16'h0000);
        push_bus(20'h00000, 4'hA, 1'b0, 16'h00BE, 1, 16'h0000);
        push_rsp(1'b0, 16'hBEEF, 1'b0, 1'b0);
        eu_op(3'd2, 20'hFFFFF, 1'b1, 16'hBEAD);

        // Reserved command code must not start a bus cycle.
        eu_cmd = 3'd5;
        repeat (3) @(posedge clk);
        #1 eu_cmd = 3'd0;
        @(negedge clk);
        check("reserved_cmd_idle", 32'(bus_status), 32'hF);

`ifdef BUS_TIMEOUT_EN
        // readyb stuck high: abort after 8 cycles with bus_error and eu_rdata=FFFF.
        push_bus(20'h00900, 4'h9, 1'b0, 16'h0000, 1000, 16'h0000);
        push_rsp(1'b0, 16'hFFFF, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        eu_op(3'd1, 20'h00900, 1'b0, 16'h0000);
`endif

        wait_idle();
        repeat (3) @(posedge clk);
        check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Bus control unit sitting between the execution unit (EU), the prefetch queue and the external V30MZ bus pins. It arbitrates the single external bus between EU data/IO transfers and instruction prefetches. It sequences each bus cycle by registering address, status, byte enable and write data, then waiting on active-low readyb. EU word accesses to odd addresses are split into two byte cycles.

Parameters:
TIMEOUT_CYCLES, 255, readyb wait limit before abort (used only with BUS_TIMEOUT_EN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
eu_cmd  input  3  0 IDLE, 1 MEM_READ, 2 MEM_WRITE, 3 IO_READ, 4 IO_WRITE; 5-7 treated as IDLE
eu_addr  input  20  EU physical address
eu_word  input  1  1 = word transfer, 0 = byte transfer
eu_wdata  input  16  write data; byte transfers use [7:0]
eu_done  output  1  one-cycle pulse; EU transfer complete
eu_rdata  output  16  read data, valid while eu_done=1; byte reads zero-extended
pf_req  input  1  prefetch queue not full and not suspended
pf_flush  input  1  queue flush (branch or interrupt)
pf_addr  input  20  fetch address, {PS,4'd0}+PFP
pf_push  output  1  one-cycle pulse; push pf_data into queue
pf_data  output  16  fetched data
pf_byte  output  1  with pf_push: odd fetch, only pf_data[15:8] valid
readyb  input  1  active-low bus ready
data_in  input  16  bus read data
data_out  output  16  bus write data
address_out  output  20  bus address
bus_status  output  4  F idle, 9 mem read/fetch, A mem write, 5 IO read, 6 IO write
bus_upper_byte_enable  output  1  high when D[15:8] is active
bus_error  output  1  timeout pulse (constant 0 without BUS_TIMEOUT_EN)

Behaviour:
- Reset: state IDLE, address_out=20'hFFFFF, bus_status=4'hF, data_out=0, bus_upper_byte_enable=0, eu_rdata=0, pf_data=0, all pulses 0, discard flag 0. Reset during an active cycle abandons the cycle immediately. No pulse is issued for it.
- States: IDLE, FETCH, EU_LO, EU_HI.
- IDLE grant, evaluated at each posedge:
  - Valid eu_cmd wins: latch cmd, addr, word and wdata, then go to EU_LO.
  - Otherwise pf_req and !pf_flush: latch pf_addr and go to FETCH.
  - eu_cmd is ignored in the cycle eu_done is high.
  - Strict EU priority with no preemption. A granted fetch always completes before the EU is served.
- Bus outputs are registered and take effect in the cycle after grant.
- In any bus state, readyb==0 at a posedge ends that bus cycle: data_in is sampled and bus_status returns to 4'hF unless another bus cycle follows. The minimum is 2 clocks per bus cycle.
- Byte lanes: even address uses D[7:0] with ube=0. Odd address uses D[15:8] with ube=1. Word at even address uses ube=1 and one cycle.
- Write data is placed on the addressed lane. For an odd byte write, data_out[15:8]=wdata[7:0].
- FETCH:
  - address_out=pf_addr, status 9.
  - ube=1 always. pf_byte=pf_addr[0], and only the upper byte is used when pf_byte=1.
  - On completion, pf_push pulses the next cycle with pf_data=data_in, unless the discard flag is set.
- pf_flush asserted while in FETCH sets the discard flag. The bus cycle still completes but pf_push is suppressed. The flag clears on return to IDLE.
- EU odd word access:
  - EU_LO: addr odd, ube=1, upper lane feeds rdata[7:0].
  - EU_HI: addr+1 with 20-bit wraparound (FFFFF->00000), ube=0, lower lane feeds rdata[15:8].
  - For writes, EU_HI drives wdata[15:8] on D[7:0].
  - A single status/ube update occurs between the two halves; there is no idle cycle between them.
- eu_done pulses in the cycle after the final completion. eu_rdata holds its value until the next EU read.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined: a counter runs in each bus state and is cleared on every new bus cycle. Reaching TIMEOUT_CYCLES with readyb still high aborts the cycle and returns to IDLE.
  - The abort pulses bus_error together with eu_done (EU cycle, eu_rdata=16'hFFFF) or with no pf_push (fetch).
- Undefined: the arbiter waits indefinitely and bus_error is tied to 0.

Test Plan:
- Reset held 3 cycles with readyb high -> address_out=FFFFF, bus_status=F, no pulses; on release with pf_req=1, pf_addr=FFFF0 -> next cycle status 9, ube 1.
- Fetch at 0x00101 with readyb low after 2 wait states, data_in=0xAB12 -> pf_push one cycle, pf_byte=1, pf_data=0xAB12.
- EU MEM_READ word at 0x2000F, lanes returning 0x34 then 0x12 -> two bus cycles at 0x2000F (ube 1) and 0x20010 (ube 0), eu_done with eu_rdata=0x1234.
- EU IO_WRITE byte addr 0x00041 wdata 0x5A concurrent with pf_req -> EU granted first, status 6, data_out[15:8]=0x5A, ube 1; fetch starts after eu_done.
- pf_flush mid-FETCH -> bus cycle completes, pf_push stays 0; a word write at FFFFF wraps its second cycle to 00000.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8 and readyb stuck high on EU MEM_READ -> after 8 cycles bus_error=1, eu_done=1, eu_rdata=FFFF, status F.
